// File: rtl/pipeline_ex_stage_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ex_pkg
// Purpose  : Shared encodings for the EX stage: M-extension op codes, MDU FSM
//            states, branch compare types, ALU function codes and default
//            widths.
// Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

  localparam int XLEN_DEF       = 64;
  localparam int RA_W_DEF       = 5;
  localparam int ALU_CTRL_W_DEF = 4;

  // M-extension ops (funct3 order)
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Iterative MDU states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Branch compare types (funct3 order)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // ALU functions
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/pipeline_ex_stage_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_iter
// Purpose  : Iterative RV M-extension unit. Shift-add multiplier and restoring
//            divider sharing one {hi,lo} register pair and one counter; one
//            bit per cycle, XLEN cycles in BUSY. Operates on magnitudes, the
//            sign is applied combinationally while in DONE.
// Ports    : clk, reset (async, active-low), abort (sync kill),
//            start (load operands, IDLE only), ack (result consumed, DONE->IDLE),
//            op/a/b operands, busy/done status, result (valid in DONE).
// Revision : 1.0 - initial release
// ============================================================================
module ex_mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic            ack,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]  opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  dvd_q, dvd_d;   // original dividend, returned as remainder on /0
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             bzero_q, bzero_d;

  logic             w_a_neg, w_b_neg;
  logic [XLEN-1:0]  w_a_mag, w_b_mag;
  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_rsh;
  logic             w_ge;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  // Operand sign handling at start
  always_comb begin
    w_a_neg = ((op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM))
              && a[XLEN-1];
    w_b_neg = ((op == MD_MULH) || (op == MD_DIV) || (op == MD_REM)) && b[XLEN-1];
    w_a_mag = w_a_neg ? -a : a;
    w_b_mag = w_b_neg ? -b : b;
  end

  // One multiply step: conditional add into hi, then shift {carry,hi,lo} right
  assign w_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  // One divide step: shift next dividend bit into the partial remainder
  assign w_rsh = {hi_q, lo_q[XLEN-1]};
  assign w_ge  = (w_rsh >= {1'b0, opb_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = w_a_mag;
          opb_d   = w_b_mag;
          dvd_d   = a;
          op_d    = op;
          // remainder takes the dividend sign; everything else the xor
          neg_d   = (op == MD_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
          bzero_d = (b == '0);
        end
      end
      ST_BUSY: begin
        if (op_q[2]) begin
          // remainder < divisor always, so the XLEN-bit subtraction is exact
          hi_d = w_ge ? (w_rsh[XLEN-1:0] - opb_q) : w_rsh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], w_ge};
        end else begin
          hi_d = w_sum[XLEN:1];
          lo_d = {w_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      dvd_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      dvd_q   <= dvd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
    end
  end

  // Sign fix-up and divide-by-zero override. Signed overflow (min / -1)
  // needs no special case: |min|/1 = min and the two signs cancel.
  always_comb begin
    w_prod     = {hi_q, lo_q};
    w_prod_fix = neg_q ? -w_prod : w_prod;
    case (op_q)
      MD_MUL:                       result = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
      default:                      result = bzero_q ? dvd_q : (neg_q ? -hi_q : hi_q);
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign done = (state_q == ST_DONE);

endmodule : ex_mdu_iter
`default_nettype wire

// File: rtl/pipeline_ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ex_stage_mdu
// Purpose  : EX stage of the 5-stage RISC-V pipeline with valid/ready on both
//            sides, flush, ALU, branch unit and iterative M-extension unit.
//            All results and sideband fields land in the EX/MEM register.
// Ports    : clk, reset (async, active-low), flush
//            ID/EX side : in_valid, in_ready, operands, decode controls,
//                         sideband (rd_in, rf_wr_*_in, dm_*_ctrl_in)
//            EX/MEM side: out_valid, out_ready, result, branch_taken,
//                         branch_target, registered sideband copies
//            md_busy    : MDU iterating
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RA_W       = RA_W_DEF,
  parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [RA_W-1:0]       rd_in,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic                  alu_a_sel,
  input  logic                  alu_b_sel,
  input  logic                  md_en,
  input  logic [2:0]            md_op,
  input  logic                  is_branch,
  input  logic                  do_jump,
  input  logic                  is_jalr,
  input  logic [2:0]            br_type,
  input  logic                  rf_wr_en_in,
  input  logic [1:0]            rf_wr_sel_in,
  input  logic [2:0]            dm_rd_ctrl_in,
  input  logic [2:0]            dm_wr_ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  branch_taken,
  output logic [XLEN-1:0]       branch_target,
  output logic [XLEN-1:0]       pc_out,
  output logic [RA_W-1:0]       rd_out,
  output logic [XLEN-1:0]       rs2_out,
  output logic                  rf_wr_en,
  output logic [1:0]            rf_wr_sel,
  output logic [2:0]            dm_rd_ctrl,
  output logic [2:0]            dm_wr_ctrl,
  output logic                  md_busy
);

  localparam int SH_W = $clog2(XLEN);

  // EX/MEM register
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            br_taken_q, br_taken_d;
  logic [XLEN-1:0] br_target_q, br_target_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            rf_wr_en_q, rf_wr_en_d;
  logic [1:0]      rf_wr_sel_q, rf_wr_sel_d;
  logic [2:0]      dm_rd_q, dm_rd_d;
  logic [2:0]      dm_wr_q, dm_wr_d;

  // Sideband of the M-op in flight; ID/EX is free to move on after accept
  logic [XLEN-1:0] md_pc_q, md_pc_d;
  logic [RA_W-1:0] md_rd_q, md_rd_d;
  logic [XLEN-1:0] md_rs2_q, md_rs2_d;
  logic            md_rf_wr_en_q, md_rf_wr_en_d;
  logic [1:0]      md_rf_wr_sel_q, md_rf_wr_sel_d;
  logic [2:0]      md_dm_rd_q, md_dm_rd_d;
  logic [2:0]      md_dm_wr_q, md_dm_wr_d;

  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic [SH_W-1:0] w_shamt;
  logic            w_br_e, w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_accept, w_load_alu, w_load_md;
  logic            w_mdu_busy, w_mdu_done;
  logic [XLEN-1:0] w_mdu_result;

  // ALU
  always_comb begin
    w_alu_a   = alu_a_sel ? rs1_data : pc_in;
    w_alu_b   = alu_b_sel ? imm : rs2_data;
    w_shamt   = w_alu_b[SH_W-1:0];
    w_alu_res = '0;
    case (alu_ctrl)
      ALU_CTRL_W'(ALU_ADD):   w_alu_res = w_alu_a + w_alu_b;
      ALU_CTRL_W'(ALU_SUB):   w_alu_res = w_alu_a - w_alu_b;
      ALU_CTRL_W'(ALU_SLL):   w_alu_res = w_alu_a << w_shamt;
      ALU_CTRL_W'(ALU_SLT):   w_alu_res[0] = ($signed(w_alu_a) < $signed(w_alu_b));
      ALU_CTRL_W'(ALU_SLTU):  w_alu_res[0] = (w_alu_a < w_alu_b);
      ALU_CTRL_W'(ALU_XOR):   w_alu_res = w_alu_a ^ w_alu_b;
      ALU_CTRL_W'(ALU_SRL):   w_alu_res = w_alu_a >> w_shamt;
      ALU_CTRL_W'(ALU_SRA):   w_alu_res = $signed(w_alu_a) >>> w_shamt;
      ALU_CTRL_W'(ALU_OR):    w_alu_res = w_alu_a | w_alu_b;
      ALU_CTRL_W'(ALU_AND):   w_alu_res = w_alu_a & w_alu_b;
      ALU_CTRL_W'(ALU_COPYB): w_alu_res = w_alu_b;
      default:                w_alu_res = '0;
    endcase
  end

  // Branch unit
  always_comb begin
    case (br_type)
      BR_BEQ:  w_br_e = (rs1_data == rs2_data);
      BR_BNE:  w_br_e = (rs1_data != rs2_data);
      BR_BLT:  w_br_e = ($signed(rs1_data) <  $signed(rs2_data));
      BR_BGE:  w_br_e = ($signed(rs1_data) >= $signed(rs2_data));
      BR_BLTU: w_br_e = (rs1_data <  rs2_data);
      BR_BGEU: w_br_e = (rs1_data >= rs2_data);
      default: w_br_e = 1'b0;
    endcase
    w_taken  = is_branch && (do_jump || w_br_e);
    w_target = is_jalr ? ((rs1_data + imm) & ~XLEN'(1)) : (pc_in + imm);
  end

  // Handshake. The MDU being out of IDLE is what blocks ID.
  assign in_ready   = !w_mdu_busy && !w_mdu_done && !flush && (!out_valid_q || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_load_alu = w_accept && !md_en;
  assign w_load_md  = w_mdu_done && !flush && (!out_valid_q || out_ready);

  ex_mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .abort  (flush),
    .start  (w_accept && md_en),
    .ack    (w_load_md),
    .op     (md_op),
    .a      (rs1_data),
    .b      (rs2_data),
    .busy   (w_mdu_busy),
    .done   (w_mdu_done),
    .result (w_mdu_result)
  );

  always_comb begin
    out_valid_d    = out_valid_q;
    result_d       = result_q;
    br_taken_d     = br_taken_q;
    br_target_d    = br_target_q;
    pc_d           = pc_q;
    rd_d           = rd_q;
    rs2_d          = rs2_q;
    rf_wr_en_d     = rf_wr_en_q;
    rf_wr_sel_d    = rf_wr_sel_q;
    dm_rd_d        = dm_rd_q;
    dm_wr_d        = dm_wr_q;
    md_pc_d        = md_pc_q;
    md_rd_d        = md_rd_q;
    md_rs2_d       = md_rs2_q;
    md_rf_wr_en_d  = md_rf_wr_en_q;
    md_rf_wr_sel_d = md_rf_wr_sel_q;
    md_dm_rd_d     = md_dm_rd_q;
    md_dm_wr_d     = md_dm_wr_q;

    if (w_accept && md_en) begin
      md_pc_d        = pc_in;
      md_rd_d        = rd_in;
      md_rs2_d       = rs2_data;
      md_rf_wr_en_d  = rf_wr_en_in;
      md_rf_wr_sel_d = rf_wr_sel_in;
      md_dm_rd_d     = dm_rd_ctrl_in;
      md_dm_wr_d     = dm_wr_ctrl_in;
    end

    // Loads are already gated by !flush; flush only needs to drop valid.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_load_alu) begin
      out_valid_d = 1'b1;
      result_d    = w_alu_res;
      br_taken_d  = w_taken;
      br_target_d = w_taken ? w_target : '0;
      pc_d        = pc_in;
      rd_d        = rd_in;
      rs2_d       = rs2_data;
      rf_wr_en_d  = rf_wr_en_in;
      rf_wr_sel_d = rf_wr_sel_in;
      dm_rd_d     = dm_rd_ctrl_in;
      dm_wr_d     = dm_wr_ctrl_in;
    end else if (w_load_md) begin
      out_valid_d = 1'b1;
      result_d    = w_mdu_result;
      br_taken_d  = 1'b0;
      br_target_d = '0;
      pc_d        = md_pc_q;
      rd_d        = md_rd_q;
      rs2_d       = md_rs2_q;
      rf_wr_en_d  = md_rf_wr_en_q;
      rf_wr_sel_d = md_rf_wr_sel_q;
      dm_rd_d     = md_dm_rd_q;
      dm_wr_d     = md_dm_wr_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      br_taken_q     <= 1'b0;
      br_target_q    <= '0;
      pc_q           <= '0;
      rd_q           <= '0;
      rs2_q          <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_wr_sel_q    <= '0;
      dm_rd_q        <= '0;
      dm_wr_q        <= '0;
      md_pc_q        <= '0;
      md_rd_q        <= '0;
      md_rs2_q       <= '0;
      md_rf_wr_en_q  <= 1'b0;
      md_rf_wr_sel_q <= '0;
      md_dm_rd_q     <= '0;
      md_dm_wr_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      br_taken_q     <= br_taken_d;
      br_target_q    <= br_target_d;
      pc_q           <= pc_d;
      rd_q           <= rd_d;
      rs2_q          <= rs2_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_wr_sel_q    <= rf_wr_sel_d;
      dm_rd_q        <= dm_rd_d;
      dm_wr_q        <= dm_wr_d;
      md_pc_q        <= md_pc_d;
      md_rd_q        <= md_rd_d;
      md_rs2_q       <= md_rs2_d;
      md_rf_wr_en_q  <= md_rf_wr_en_d;
      md_rf_wr_sel_q <= md_rf_wr_sel_d;
      md_dm_rd_q     <= md_dm_rd_d;
      md_dm_wr_q     <= md_dm_wr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign branch_taken  = br_taken_q;
  assign branch_target = br_target_q;
  assign pc_out        = pc_q;
  assign rd_out        = rd_q;
  assign rs2_out       = rs2_q;
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_wr_sel     = rf_wr_sel_q;
  assign dm_rd_ctrl    = dm_rd_q;
  assign dm_wr_ctrl    = dm_wr_q;
  assign md_busy       = w_mdu_busy;

endmodule : pipeline_ex_stage_mdu
`default_nettype wire

// File: tb/tb_pipeline_ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ex_stage_mdu
// Purpose  : Self-checking bench for pipeline_ex_stage_mdu (XLEN=64): directed
//            handshake/branch/M-op/flush/reset steps plus random ALU and M ops
//            checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ex_stage_mdu;
  import ex_pkg::*;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] C_MIN = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush, in_valid, in_ready;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc_in;
  logic [4:0]      rd_in;
  logic [3:0]      alu_ctrl;
  logic            alu_a_sel, alu_b_sel, md_en;
  logic [2:0]      md_op;
  logic            is_branch, do_jump, is_jalr;
  logic [2:0]      br_type;
  logic            rf_wr_en_in;
  logic [1:0]      rf_wr_sel_in;
  logic [2:0]      dm_rd_ctrl_in, dm_wr_ctrl_in;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result, branch_target, pc_out, rs2_out;
  logic            branch_taken, rf_wr_en, md_busy;
  logic [4:0]      rd_out;
  logic [1:0]      rf_wr_sel;
  logic [2:0]      dm_rd_ctrl, dm_wr_ctrl;

  int total = 0;
  int bad   = 0;

  pipeline_ex_stage_mdu #(.XLEN(XLEN), .RA_W(5), .ALU_CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in), .rd_in(rd_in),
    .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .md_en(md_en),
    .md_op(md_op), .is_branch(is_branch), .do_jump(do_jump), .is_jalr(is_jalr),
    .br_type(br_type), .rf_wr_en_in(rf_wr_en_in), .rf_wr_sel_in(rf_wr_sel_in),
    .dm_rd_ctrl_in(dm_rd_ctrl_in), .dm_wr_ctrl_in(dm_wr_ctrl_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .rd_out(rd_out), .rs2_out(rs2_out),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .dm_rd_ctrl(dm_rd_ctrl),
    .dm_wr_ctrl(dm_wr_ctrl), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; flush = 0; md_en = 0; md_op = 0; is_branch = 0; do_jump = 0; is_jalr = 0;
    br_type = 0; alu_ctrl = ALU_ADD; alu_a_sel = 1; alu_b_sel = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc_in = 0; rd_in = 0;
    rf_wr_en_in = 0; rf_wr_sel_in = 0; dm_rd_ctrl_in = 0; dm_wr_ctrl_in = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] md_model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] sa, sb, ua, ub, p;
    logic signed [XLEN-1:0] q;
    sa = {{XLEN{a[XLEN-1]}}, a};
    sb = {{XLEN{b[XLEN-1]}}, b};
    ua = {{XLEN{1'b0}}, a};
    ub = {{XLEN{1'b0}}, b};
    p = '0;
    q = '0;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[XLEN-1:0]; end
      MD_MULH:   begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
      MD_MULHSU: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
      MD_MULHU:  begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
      MD_DIV: begin
        if (b == 0) return '1;
        if (a == C_MIN && b == '1) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      MD_DIVU: return (b == 0) ? '1 : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == C_MIN && b == '1) return '0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_model(input logic [3:0] f, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] s;
    s = $signed(a) >>> b[5:0];
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[5:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[5:0];
      ALU_SRA:  return s;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return b;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return C_MIN;
      3: return 64'($urandom_range(0, 300));
      4: return -64'($urandom_range(1, 300));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one ALU op (rs1 op rs2) with MEM ready; expect it in EX/MEM next cycle.
  task automatic run_alu(input string tag, input logic [3:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    logic [XLEN-1:0] exp;
    exp = alu_model(f, a, b);
    in_valid = 1; md_en = 0; alu_ctrl = f; rs1_data = a; rs2_data = b;
    alu_a_sel = 1; alu_b_sel = 0; is_branch = 0; rd_in = 5'd3;
    step();
    in_valid = 0;
    check_b({tag, ":valid"}, out_valid, 1'b1);
    check(tag, result, exp);
  endtask

  // Issue one M op; measure latency and check result and carried sideband.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit timing);
    logic [XLEN-1:0] exp, pc;
    int n, low;
    exp = md_model(op, a, b);
    pc = {$urandom, $urandom};
    in_valid = 1; md_en = 1; md_op = op; rs1_data = a; rs2_data = b; pc_in = pc; rd_in = 5'd9;
    is_branch = 0;
    step();
    // scramble ID/EX after accept: the op in flight must not depend on it
    in_valid = 0; md_en = 0; rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    pc_in = 0; rd_in = 0;
    n = 0; low = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) low++;
      step();
      n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(XLEN + 1));
    if (timing) begin
      check({tag, ":in_ready_low"}, 64'(low), 64'(XLEN + 1));
      check_b({tag, ":in_ready_after"}, in_ready, 1'b1);
      check({tag, ":pc_out"}, pc_out, pc);
    end
    check({tag, ":rd_out"}, 64'(rd_out), 64'd9);
    check(tag, result, exp);
    step();  // retire
  endtask

  initial begin
    clear_in();
    out_ready = 1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check_b("rst:out_valid", out_valid, 1'b0);
    check("rst:result", result, '0);
    check_b("rst:md_busy", md_busy, 1'b0);
    check_b("rst:branch_taken", branch_taken, 1'b0);
    reset = 1;
    step();
    check_b("rst:in_ready", in_ready, 1'b1);

    // ---- 1: ADD rs1 + imm ----
    in_valid = 1; alu_ctrl = ALU_ADD; alu_b_sel = 1; rs1_data = 5; imm = 7; rd_in = 5'd1;
    rf_wr_en_in = 1; rf_wr_sel_in = 2'd2; dm_rd_ctrl_in = 3'd5; dm_wr_ctrl_in = 3'd6;
    step();
    in_valid = 0;
    #1;
    check_b("add:valid", out_valid, 1'b1);
    check("add:result", result, 64'd12);
    check_b("add:in_ready", in_ready, 1'b1);
    check("add:sideband", 64'({rd_out, rf_wr_en, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl}),
          64'({5'd1, 1'b1, 2'd2, 3'd5, 3'd6}));
    step();
    check_b("add:retire", out_valid, 1'b0);
    clear_in();

    // ---- 2: branches ----
    in_valid = 1; is_branch = 1; br_type = BR_BEQ; rs1_data = 3; rs2_data = 3;
    pc_in = 64'h100; imm = 64'h20;
    step();
    check_b("beq:taken", branch_taken, 1'b1);
    check("beq:target", branch_target, 64'h120);
    br_type = BR_BNE;
    step();
    check_b("bne:taken", branch_taken, 1'b0);
    check("bne:target", branch_target, '0);
    br_type = BR_BLT; rs1_data = '1; rs2_data = 1;  // -1 < 1 signed
    step();
    check_b("blt:taken", branch_taken, 1'b1);
    br_type = BR_BLTU;                              // all-ones !< 1 unsigned
    step();
    check_b("bltu:taken", branch_taken, 1'b0);
    do_jump = 1; is_jalr = 1; rs1_data = 64'h1003; imm = 64'h10;
    step();
    in_valid = 0;
    check_b("jalr:taken", branch_taken, 1'b1);
    check("jalr:target", branch_target, 64'h1012);
    step();
    clear_in();

    // ---- 3: MUL / MULHU ----
    run_md("mul", MD_MUL, -64'sd3, 64'd7, 1'b1);
    run_md("mulhu", MD_MULHU, '1, '1, 1'b0);
    run_md("mulh", MD_MULH, C_MIN, '1, 1'b0);
    run_md("mulhsu", MD_MULHSU, '1, '1, 1'b0);

    // ---- 4: divide corner cases ----
    run_md("div0", MD_DIV, 64'd7, '0, 1'b0);
    run_md("rem0", MD_REM, 64'd7, '0, 1'b0);
    run_md("div_ovf", MD_DIV, C_MIN, '1, 1'b0);
    run_md("rem_ovf", MD_REM, C_MIN, '1, 1'b0);
    run_md("rem_neg", MD_REM, -64'sd7, 64'd2, 1'b0);

    // ---- 5: DIVU / REMU, then flush mid-op ----
    run_md("divu", MD_DIVU, 64'd100, 64'd7, 1'b0);
    run_md("remu", MD_REMU, 64'd100, 64'd7, 1'b0);
    in_valid = 1; md_en = 1; md_op = MD_DIVU; rs1_data = 100; rs2_data = 7;
    step();
    in_valid = 0; md_en = 0;
    repeat (10) step();
    check_b("flush:busy_before", md_busy, 1'b1);
    in_valid = 1; alu_ctrl = ALU_ADD; rs1_data = 40; rs2_data = 2; rd_in = 5'd4;
    flush = 1;
    #1;
    check_b("flush:in_ready", in_ready, 1'b0);
    step();
    flush = 0;
    #1;
    check_b("flush:md_busy", md_busy, 1'b0);
    check_b("flush:out_valid", out_valid, 1'b0);
    check_b("flush:in_ready_after", in_ready, 1'b1);
    step();
    in_valid = 0;
    check_b("flush:add_valid", out_valid, 1'b1);
    check("flush:add_result", result, 64'd42);
    step();

    // ---- 6: MEM back-pressure, retire+load on one edge ----
    out_ready = 0;
    in_valid = 1; rs1_data = 1; rs2_data = 2; rd_in = 5'd5;
    step();
    rs1_data = 10; rs2_data = 20; rd_in = 5'd6;
    for (int i = 0; i < 3; i++) begin
      check_b("stall:valid", out_valid, 1'b1);
      check("stall:result", result, 64'd3);
      check_b("stall:in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1;
    #1;
    check_b("stall:in_ready_release", in_ready, 1'b1);
    step();
    in_valid = 0;
    check_b("swap:valid", out_valid, 1'b1);
    check("swap:result", result, 64'd30);
    check("swap:rd", 64'(rd_out), 64'd6);
    step();
    check_b("swap:retire", out_valid, 1'b0);

    // ---- reset asserted mid-divide ----
    in_valid = 1; md_en = 1; md_op = MD_DIV; rs1_data = 1000; rs2_data = 3; rd_in = 5'd7;
    step();
    in_valid = 0; md_en = 0;
    repeat (5) step();
    check_b("rstmid:busy", md_busy, 1'b1);
    #2 reset = 0;
    #1;
    check("rstmid:result", result, '0);
    check("rstmid:rd_out", 64'(rd_out), '0);
    check_b("rstmid:md_busy", md_busy, 1'b0);
    check_b("rstmid:out_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1;
    step();
    check_b("rstmid:in_ready", in_ready, 1'b1);
    clear_in();

    // ---- random ALU ops ----
    for (int i = 0; i < 24; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 10));
      run_alu("rand_alu", f, pick_operand(), pick_operand());
    end
    step();

    // ---- random M ops ----
    for (int i = 0; i < 16; i++) begin
      run_md("rand_md", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_ex_stage_mdu
`default_nettype wire
